// File: rtl/idma_pkg.sv
// Shared types and constants for the iDMA read-descriptor generator.
package idma_pkg;

    localparam int unsigned IDMA_ADDR_W     = 32;
    localparam int unsigned IDMA_CNT_W      = 16;
    localparam int unsigned IDMA_WORD_BYTES = 32;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN,
        DONE
    } desc_gen_state_e;

    typedef struct packed {
        logic [IDMA_ADDR_W-1:0] addr;
        logic [IDMA_CNT_W-1:0]  words;
    } rd_desc_t;

endpackage

// File: rtl/idma_rd_desc_gen_if.sv
// Descriptor FIFO read port seen by the AXI read interface (head data, empty, pop).
interface idma_rd_desc_gen_if;

    logic [31:0] raddr_fifo_raddr_in;
    logic [31:0] raddr_fifo_rd_num_word;
    logic        raddr_fifo_empty;
    logic        raddr_fifo_pop;

    modport master (
        output raddr_fifo_raddr_in,
        output raddr_fifo_rd_num_word,
        output raddr_fifo_empty,
        input  raddr_fifo_pop
    );

    modport slave (
        input  raddr_fifo_raddr_in,
        input  raddr_fifo_rd_num_word,
        input  raddr_fifo_empty,
        output raddr_fifo_pop
    );

endinterface

// File: rtl/idma_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data reads as zero while empty.
module idma_sync_fifo #(
    parameter int unsigned Width = 48,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign count_o = wptr_q - rptr_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[PtrW-1:0]];

endmodule

// File: rtl/idma_rd_desc_gen.sv
// 2D read-descriptor generator: expands a block config into one {addr, words} entry per row.
module idma_rd_desc_gen
    import idma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = IDMA_ADDR_W,
    parameter int unsigned CNT_W      = IDMA_CNT_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_row_words,
    input  logic [CNT_W-1:0]  cfg_row_num,
    input  logic [ADDR_W-1:0] cfg_row_stride,
    idma_rd_desc_gen_if.master rd_if,
    output logic              gen_busy,
    output logic              gen_done
);

    localparam int unsigned DescW = ADDR_W + CNT_W;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    desc_gen_state_e   state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] row_stride_q, row_stride_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]  row_num_q, row_num_d;
    logic [CNT_W-1:0]  row_words_q, row_words_d;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_ok;
    logic [CntW-1:0]   fifo_count;
    logic [DescW-1:0]  fifo_rdata;

    idma_sync_fifo #(
        .Width (DescW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .clr_i   (cfg_abort),
        .push_i  (fifo_push),
        .wdata_i ({cur_addr_q, row_words_q}),
        .pop_i   (rd_if.raddr_fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pop_ok = rd_if.raddr_fifo_pop & ~fifo_empty;

    assign rd_if.raddr_fifo_raddr_in    = 32'(fifo_rdata[DescW-1:CNT_W]);
    assign rd_if.raddr_fifo_rd_num_word = 32'(fifo_rdata[CNT_W-1:0]);
    assign rd_if.raddr_fifo_empty       = fifo_empty;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        row_stride_d = row_stride_q;
        row_cnt_d    = row_cnt_q;
        row_num_d    = row_num_q;
        row_words_d  = row_words_q;
        fifo_push    = 1'b0;
        cfg_ready    = 1'b0;
        gen_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    cur_addr_d   = cfg_base_addr;
                    row_stride_d = cfg_row_stride;
                    row_num_d    = cfg_row_num;
                    row_words_d  = cfg_row_words;
                    row_cnt_d    = '0;
                    if (cfg_row_num == '0 || cfg_row_words == '0) state_d = DONE;
                    else                                          state_d = GEN;
                end
            end
            GEN: begin
                if (!fifo_full || pop_ok) begin
                    fifo_push  = 1'b1;
                    cur_addr_d = cur_addr_q + row_stride_q;
                    row_cnt_d  = row_cnt_q + CNT_W'(1);
                    if (row_cnt_q == row_num_q - CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Done as soon as the FIFO is empty after this cycle's pop.
                if (fifo_count == '0 || (fifo_count == CntW'(1) && pop_ok)) state_d = DONE;
            end
            DONE: begin
                gen_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cfg_abort) begin
            state_d   = IDLE;
            fifo_push = 1'b0;
        end
    end

    assign gen_busy = (state_q != IDLE);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            row_stride_q <= '0;
            row_cnt_q    <= '0;
            row_num_q    <= '0;
            row_words_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            row_stride_q <= row_stride_d;
            row_cnt_q    <= row_cnt_d;
            row_num_q    <= row_num_d;
            row_words_q  <= row_words_d;
        end
    end

endmodule
